// File: rtl/debug_pkg.sv
// Shared definitions for the debug unit.
//   run_state_e   : run-control FSM encoding (HALT / STEP / RUN)
//   SelMemView    : display-select code for the memory/regfile view
//   DbCyclesDefault: default debounce length in clocks
package debug_pkg;

  typedef enum logic [1:0] {
    StHalt = 2'd0,
    StStep = 2'd1,
    StRun  = 2'd2
  } run_state_e;

  localparam logic [2:0] SelMemView = 3'd0;

  localparam int unsigned DbCyclesDefault = 4;

endpackage

// File: rtl/btn_cond.sv
// Conditions one raw switch/button bit: 2-flop synchronizer, debounce, rising-edge pulse.
//   clk, rst : clock, asynchronous active-high reset
//   raw      : raw asynchronous input
//   level    : debounced level (changes after DB_CYCLES equal synchronized samples)
//   pulse    : one-cycle pulse on each accepted rising edge of level
module btn_cond
  import debug_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            valid1_q, valid2_q;
  logic            level_q, level_d;
  logic            prev_q;
  logic            armed_q, armed_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] low_cnt_q, low_cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // A pulse is only allowed once a genuine released state has been accepted since reset,
  // so a button held through reset release stays silent until released and pressed again.
  // The valid flops mask the reset-value samples still flowing out of the synchronizer.
  always_comb begin
    armed_d   = armed_q;
    low_cnt_d = low_cnt_q;
    if (!armed_q) begin
      if (valid2_q && !sync2_q) begin
        if (low_cnt_q == CntLast) begin
          armed_d = 1'b1;
        end else begin
          low_cnt_d = low_cnt_q + 1'b1;
        end
      end else begin
        low_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      valid1_q  <= 1'b0;
      valid2_q  <= 1'b0;
      level_q   <= 1'b0;
      prev_q    <= 1'b0;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      low_cnt_q <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      valid1_q  <= 1'b1;
      valid2_q  <= valid1_q;
      level_q   <= level_d;
      prev_q    <= level_q;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      low_cnt_q <= low_cnt_d;
    end
  end

  assign level = level_q;
  assign pulse = level_q & ~prev_q & armed_q;

endmodule

// File: rtl/debug_unit.sv
// Board-level debug unit for a pipelined CPU: run control (halt/step/run), memory/regfile
// address browsing and LED/seven-segment display multiplexing.
//   clk, rst            : clock, asynchronous active-high reset
//   succ, step          : raw run switch / single-step button
//   sel, m_rf           : raw display-select and memory-vs-regfile switches
//   inc, dec            : raw address browse buttons
//   cpu_status, m_data, rf_data, sel_data : CPU debug inputs
//   run                 : CPU clock enable
//   m_rf_addr, i_sel    : debug read address and internal select to the CPU
//   led, seg_data       : registered display words
module debug_unit
  import debug_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        succ,
  input  logic        step,
  input  logic [2:0]  sel,
  input  logic        m_rf,
  input  logic        inc,
  input  logic        dec,
  input  logic [15:0] cpu_status,
  input  logic [31:0] m_data,
  input  logic [31:0] rf_data,
  input  logic [31:0] sel_data,
  output logic        run,
  output logic [15:0] m_rf_addr,
  output logic [2:0]  i_sel,
  output logic [15:0] led,
  output logic [31:0] seg_data
);

  localparam int unsigned NumCh = 8;

  // Channel map: 0 succ, 1 step, 4:2 sel, 5 m_rf, 6 inc, 7 dec
  logic [NumCh-1:0] raw_vec, level_vec, pulse_vec;

  assign raw_vec = {dec, inc, m_rf, sel, step, succ};

  for (genvar g = 0; g < NumCh; g++) begin : g_cond
    btn_cond #(
      .DB_CYCLES(DB_CYCLES)
    ) u_cond (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_vec[g]),
      .level(level_vec[g]),
      .pulse(pulse_vec[g])
    );
  end

  logic       succ_lvl, m_rf_lvl, step_pulse, inc_pulse, dec_pulse;
  logic [2:0] sel_lvl;
  logic       unused_pulse;

  assign succ_lvl     = level_vec[0];
  assign step_pulse   = pulse_vec[1];
  assign sel_lvl      = level_vec[4:2];
  assign m_rf_lvl     = level_vec[5];
  assign inc_pulse    = pulse_vec[6];
  assign dec_pulse    = pulse_vec[7];
  assign unused_pulse = ^{pulse_vec[5:2], pulse_vec[0]};

  run_state_e  state_q, state_d;
  logic        run_q, run_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] led_q, led_d;
  logic [31:0] seg_q, seg_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHalt: begin
        if (succ_lvl) begin
          state_d = StRun;
        end else if (step_pulse) begin
          state_d = StStep;
        end
      end
      StStep:  state_d = StHalt;
      StRun:   if (!succ_lvl) state_d = StHalt;
      default: state_d = StHalt;
    endcase
    run_d = (state_d != StHalt);
  end

  always_comb begin
    addr_d = addr_q;
    if (sel_lvl == SelMemView) begin
      if (inc_pulse && !dec_pulse) begin
        addr_d = addr_q + 16'd1;
      end else if (dec_pulse && !inc_pulse) begin
        addr_d = addr_q - 16'd1;
      end
    end
    if (sel_lvl == SelMemView) begin
      seg_d = m_rf_lvl ? m_data : rf_data;
      led_d = addr_q;
    end else begin
      seg_d = sel_data;
      led_d = cpu_status;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StHalt;
      run_q   <= 1'b0;
      addr_q  <= '0;
      led_q   <= '0;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      addr_q  <= addr_d;
      led_q   <= led_d;
      seg_q   <= seg_d;
    end
  end

  assign run       = run_q;
  assign m_rf_addr = addr_q;
  assign i_sel     = sel_lvl;
  assign led       = led_q;
  assign seg_data  = seg_q;

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: directed scenarios plus randomized stimulus, every
// cycle compared against a behavioural model built from sample histories.
module tb_debug_unit;

  localparam int unsigned DB = 4;
  localparam int MHalt = 0;
  localparam int MStep = 1;
  localparam int MRun  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        succ = 1'b0, step = 1'b0, m_rf = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [15:0] cpu_status = '0;
  logic [31:0] m_data = '0, rf_data = '0, sel_data = '0;
  logic        run;
  logic [15:0] m_rf_addr, led;
  logic [2:0]  i_sel;
  logic [31:0] seg_data;

  debug_unit #(
    .DB_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .succ      (succ),
    .step      (step),
    .sel       (sel),
    .m_rf      (m_rf),
    .inc       (inc),
    .dec       (dec),
    .cpu_status(cpu_status),
    .m_data    (m_data),
    .rf_data   (rf_data),
    .sel_data  (sel_data),
    .run       (run),
    .m_rf_addr (m_rf_addr),
    .i_sel     (i_sel),
    .led       (led),
    .seg_data  (seg_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // raw_hist holds the raw input vector seen at each clock edge since reset (newest last).
  bit [7:0]    raw_hist[$];
  int          pushes;
  bit [7:0]    m_level, m_prev, m_armed;
  int          m_state;
  logic        m_run;
  logic [15:0] m_addr, m_led;
  logic [31:0] m_seg;

  // True when the DB synchronized samples feeding the current edge all equal v.
  // Samples that predate reset release count as 0, or as a miss when need_valid is set.
  function automatic bit window_all(input int ch, input bit v, input bit need_valid);
    for (int j = 0; j < int'(DB); j++) begin
      int back;
      bit s;
      back = 2 + j;
      if (pushes < back) begin
        if (need_valid) return 1'b0;
        s = 1'b0;
      end else begin
        s = raw_hist[raw_hist.size() - back][ch];
      end
      if (s != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    raw_hist.delete();
    pushes  = 0;
    m_level = '0;
    m_prev  = '0;
    m_armed = '0;
    m_state = MHalt;
    m_run   = 1'b0;
    m_addr  = '0;
    m_led   = '0;
    m_seg   = '0;
  endtask

  task automatic model_edge();
    bit [7:0] pulse, nl, na;
    bit [2:0] sel_l;
    pulse = m_level & ~m_prev & m_armed;
    sel_l = m_level[4:2];
    nl = m_level;
    na = m_armed;
    for (int ch = 0; ch < 8; ch++) begin
      if (window_all(ch, ~m_level[ch], 1'b0)) nl[ch] = ~m_level[ch];
      if (window_all(ch, 1'b0, 1'b1)) na[ch] = 1'b1;
    end
    if (sel_l == 3'd0) begin
      m_seg = m_level[5] ? m_data : rf_data;
      m_led = m_addr;
      if (pulse[6] && !pulse[7]) m_addr = m_addr + 16'd1;
      if (pulse[7] && !pulse[6]) m_addr = m_addr - 16'd1;
    end else begin
      m_seg = sel_data;
      m_led = cpu_status;
    end
    case (m_state)
      MHalt:   m_state = m_level[0] ? MRun : (pulse[1] ? MStep : MHalt);
      MStep:   m_state = MHalt;
      default: m_state = m_level[0] ? MRun : MHalt;
    endcase
    m_run   = (m_state != MHalt);
    m_prev  = m_level;
    m_level = nl;
    m_armed = na;
    raw_hist.push_back({dec, inc, m_rf, sel, step, succ});
    pushes++;
    if (raw_hist.size() > 32) void'(raw_hist.pop_front());
  endtask

  task automatic compare_all();
    check_eq("cyc_run", 32'(run), 32'(m_run));
    check_eq("cyc_addr", 32'(m_rf_addr), 32'(m_addr));
    check_eq("cyc_isel", 32'(i_sel), 32'(m_level[4:2]));
    check_eq("cyc_led", 32'(led), 32'(m_led));
    check_eq("cyc_seg", seg_data, m_seg);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Asserts reset mid-cycle, checks the outputs clear at once, releases on a falling edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("rst_run", 32'(run), 32'd0);
    check_eq("rst_addr", 32'(m_rf_addr), 32'd0);
    check_eq("rst_led", 32'(led), 32'd0);
    check_eq("rst_seg", seg_data, 32'd0);
    check_eq("rst_isel", 32'(i_sel), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input bit is_inc, input bit is_dec, input int hold);
    inc = is_inc;
    dec = is_dec;
    idle(hold);
    inc = 1'b0;
    dec = 1'b0;
    idle(hold);
  endtask

  int first, cnt;

  initial begin
    model_reset();
    #1;
    rst = 1'b1;
    #1;
    compare_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(10);

    // single step: held 10 cycles, exactly one run cycle after DB+3 edges
    first = 0;
    cnt = 0;
    step = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      if (i == 11) step = 1'b0;
      tick();
      if (run) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    check_eq("step_latency", 32'(first), 32'(DB + 3));
    check_eq("step_cycles", 32'(cnt), 32'd1);

    // continuous run with ignored step presses, then stop latency
    succ = 1'b1;
    idle(10);
    cnt = 0;
    step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 6) step = 1'b0;
      tick();
      if (run) cnt++;
    end
    check_eq("run_held", 32'(cnt), 32'd20);
    succ = 1'b0;
    first = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (!run && first == 0) first = i;
    end
    check_eq("run_stop_latency", 32'(first), 32'(DB + 3));

    // address wrap in both directions and simultaneous inc+dec
    press(1'b0, 1'b1, 8);
    check_eq("addr_dec_wrap", 32'(m_rf_addr), 32'hFFFF);
    press(1'b1, 1'b0, 8);
    check_eq("addr_inc_wrap", 32'(m_rf_addr), 32'h0000);
    press(1'b1, 1'b1, 8);
    check_eq("addr_both", 32'(m_rf_addr), 32'h0000);

    // bounce shorter than the debounce window
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step = (i < 3) ? ((i % 2) == 0) : 1'b0;
      tick();
      if (run) cnt++;
    end
    check_eq("bounce_run", 32'(cnt), 32'd0);
    sel = 3'd3;
    idle(10);
    press(1'b1, 1'b0, 8);
    check_eq("addr_sel_nonzero", 32'(m_rf_addr), 32'h0000);

    // display mux
    sel = 3'd0;
    idle(10);
    m_rf = 1'b1;
    m_data = 32'h12345678;
    idle(10);
    check_eq("seg_mem", seg_data, 32'h12345678);
    check_eq("led_addr", 32'(led), 32'(m_rf_addr));
    m_rf = 1'b0;
    rf_data = 32'hDEADBEEF;
    idle(10);
    check_eq("seg_rf", seg_data, 32'hDEADBEEF);
    sel = 3'd5;
    sel_data = 32'hA5A5A5A5;
    cpu_status = 16'h00F0;
    idle(10);
    check_eq("isel_5", 32'(i_sel), 32'd5);
    check_eq("seg_sel", seg_data, 32'hA5A5A5A5);
    check_eq("led_status", 32'(led), 32'h00F0);

    // reset during RUN at address 0x10; RUN resumes DB+3 cycles after release
    sel = 3'd0;
    idle(10);
    for (int i = 0; i < 16; i++) press(1'b1, 1'b0, 6);
    check_eq("addr_16", 32'(m_rf_addr), 32'h0010);
    succ = 1'b1;
    idle(12);
    check_eq("run_before_rst", 32'(run), 32'd1);
    do_reset();
    first = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (run && first == 0) first = i;
    end
    check_eq("run_resume", 32'(first), 32'(DB + 3));
    succ = 1'b0;
    idle(12);

    // step held across reset release gives nothing until released and pressed again
    step = 1'b1;
    idle(10);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (run) cnt++;
    end
    check_eq("held_across_rst", 32'(cnt), 32'd0);
    step = 1'b0;
    idle(10);
    step = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) step = 1'b0;
      tick();
      if (run) cnt++;
    end
    check_eq("repress_after_rst", 32'(cnt), 32'd1);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) step = ~step;
      if ($urandom_range(7) == 0) inc = ~inc;
      if ($urandom_range(7) == 0) dec = ~dec;
      if ($urandom_range(11) == 0) m_rf = ~m_rf;
      if ($urandom_range(59) == 0) succ = ~succ;
      if ($urandom_range(39) == 0) sel = $urandom_range(1) ? 3'd0 : 3'($urandom_range(7));
      m_data     = $urandom;
      rf_data    = $urandom;
      sel_data   = $urandom;
      cpu_status = 16'($urandom);
      if ($urandom_range(499) == 0) do_reset();
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
